multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multi-cycle successor to the single-cycle main decoder: a Moore FSM that sequences one MIPS instruction over 3–5+ cycles, driving the datapath's PC, memory, IR, ALU and register-file controls. It sits beside the shared-memory multi-cycle datapath, takes the opcode from the instruction register, stalls on a memory-ready handshake and traps undefined opcodes instead of leaving outputs stale.

## Interface
- OPCODE_W, 6, opcode field width
- ALUOP_W, 3, ALUOp width to the ALU control (widened from 2 to give andi/ori/slti distinct ops)
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- Opcode  input  OPCODE_W  IR[31:26]; stable from DECODE until the next FETCH
- mem_ready  input  1  memory completes access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite, RegDst, ALUSrcA  output  1 each
- ALUSrcB  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUOp  output  ALUOP_W  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- instr_done  output  1  one-cycle pulse in an instruction's final state
- illegal_op  output  1  one-cycle pulse in TRAP

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101, slti 001010.
- Every output is 0 unless listed for the current state.
- FETCH: MemRead, IRWrite, ALUSrcB=01, ALUOp=000, PCWrite (IorD=0, ALUSrcA=0). IRWrite/PCWrite asserted only when mem_ready=1; MemRead held throughout. Stay while mem_ready=0; else → DECODE.
- DECODE: ALUSrcB=11, ALUOp=000. → MEM_ADDR (lw/sw), EXEC (R), BRANCH (beq), JUMP (j), IMM_EXEC (addi/andi/ori/slti), TRAP (other).
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. → MEM_RD (lw) / MEM_WR (sw).
- MEM_RD: MemRead, IorD. Wait on mem_ready; → MEM_WB.
- MEM_WB: RegWrite, MemToReg, RegDst=0, instr_done. → FETCH.
- MEM_WR: MemWrite, IorD; instr_done when mem_ready=1. Wait; → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. → ALU_WB.
- ALU_WB: RegWrite, RegDst=1, instr_done. → FETCH.
- IMM_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp = 000/011/100/101 for addi/andi/ori/slti. → IMM_WB.
- IMM_WB: RegWrite, RegDst=0, MemToReg=0, instr_done. → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond, PCSource=01, instr_done. → FETCH.
- JUMP: PCWrite, PCSource=10, instr_done. → FETCH.
- TRAP: illegal_op, no writes; PC already advanced past offending word. → FETCH.
- Unreachable state encodings → FETCH next cycle, outputs 0.

## Timing
- rst_n low at a rising edge: state ← FETCH. While rst_n is low all outputs are forced 0 (combinational gate), so no write strobe is seen during reset.
- Reset mid-instruction abandons it; no partial write follows release.
- Outputs decode from the state register (IMM_EXEC also uses Opcode); valid same cycle as state.
- Latency with mem_ready tied 1: beq/j/TRAP 3, R/sw/I-ALU 4, lw 5 cycles. Each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds exactly one cycle, outputs held unchanged.
- instr_done and illegal_op never both high; at most one per instruction.

## Structure
- Package cu_pkg: opcode localparams, ALUOp codes, ALUSrcB/PCSource codes, state enum (4-bit, 13 states).
- One combinational sub-module natural: cu_output_decode (state, Opcode → control vector); FSM register and next-state logic stay in the top.

## Test plan
- lw, mem_ready=1 → states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; RegWrite=MemToReg=1 only in cycle 5; instr_done cycle 5.
- sw with mem_ready=0 for 2 cycles in MEM_WR → MemWrite held 3 cycles, instr_done on third, 6 cycles total, RegWrite never 1.
- ori (001101) then slti (001010) → ALUOp=100 then 101 in IMM_EXEC; RegDst=0 in IMM_WB.
- beq → PCWriteCond=1, PCSource=01, ALUOp=001 in cycle 3; j → PCWrite=1, PCSource=10 in cycle 3.
- Opcode 111111 → illegal_op one cycle in cycle 3, RegWrite/MemWrite/PCWrite 0 there, next state FETCH.
- rst_n low during MEM_WR stall → all outputs 0 while low; after release, FETCH with MemRead=1, no MemWrite.

Source files
------------

// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cu_pkg
//  Description : Shared constants and types for the multi-cycle control unit:
//                opcodes, ALUOp / ALUSrcB / PCSource codes, state encodings
//                and the packed control vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package cu_pkg;

  localparam int OPCODE_W = 6;
  localparam int ALUOP_W  = 3;
  localparam int STATE_W  = 4;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // ALUOp codes to the ALU control
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM state encodings (13 of 16 used; the rest recover to FETCH)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC     = 4'd6;
  localparam logic [3:0] S_ALU_WB   = 4'd7;
  localparam logic [3:0] S_IMM_EXEC = 4'd8;
  localparam logic [3:0] S_IMM_WB   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  // Full control vector driven toward the datapath
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // ALUOp for the immediate-ALU group; addi and anything unexpected add
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu_op = ALUOP_AND;
      OP_ORI:  imm_alu_op = ALUOP_OR;
      OP_SLTI: imm_alu_op = ALUOP_SLT;
      default: imm_alu_op = ALUOP_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cu_output_decode.sv
`default_nettype none
// ============================================================================
//  Module      : cu_output_decode
//  Description : Moore output decode: maps the current state (plus the opcode
//                in IMM_EXEC and the memory handshake qualifiers) onto the
//                control vector. Every field defaults to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module cu_output_decode
  import cu_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Per-state control assertions; unlisted fields and unknown states stay 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // Keep reading until memory answers; latch IR and bump PC only then
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target while registers are read
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        // The store finishes in the cycle memory accepts it
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_IMM_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(opcode);
      end
      S_IMM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_TRAP: begin
        // PC was already advanced in FETCH; just flag and move on
        ctrl.illegal_op = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Moore FSM sequencing one MIPS instruction over several
//                cycles. Holds the state register and next-state logic; the
//                control vector comes from cu_output_decode and is forced to
//                0 while reset is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W = cu_pkg::OPCODE_W,
  parameter int ALUOP_W  = cu_pkg::ALUOP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                instr_done,
  output logic                illegal_op
);

  logic [3:0] state;
  logic [3:0] state_next;
  ctrl_t      ctrl_raw;
  ctrl_t      ctrl;

  // State register; reset returns to FETCH and abandons any instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic with memory-ready stalls and opcode dispatch
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:                     state_next = S_MEM_ADDR;
          OP_RTYPE:                         state_next = S_EXEC;
          OP_BEQ:                           state_next = S_BRANCH;
          OP_J:                             state_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_IMM_EXEC;
          default:                          state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_next = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_next = S_FETCH;
      S_MEM_WR:   state_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC:     state_next = S_ALU_WB;
      S_ALU_WB:   state_next = S_FETCH;
      S_IMM_EXEC: state_next = S_IMM_WB;
      S_IMM_WB:   state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_TRAP:     state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  cu_output_decode u_output_decode (
    .state     (state),
    .opcode    (Opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_raw)
  );

  // Gate every strobe off while reset is held so no write escapes
  always_comb begin
    ctrl = rst_n ? ctrl_raw : '0;
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemToReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = ctrl.illegal_op;

endmodule
`default_nettype wire
